// File: rtl/pwm_fade_ctrl.sv
// Fade controller for a PWM driver: steps the driver's cutoff value from its
// current setting toward a requested target at a fixed per-step interval.
module pwm_fade_ctrl #(
  parameter logic [7:0] INIT_CUTOFF = 8'h7f,
  parameter int         INTERVAL_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_target,
  input  logic [7:0]            req_step,
  input  logic [INTERVAL_W-1:0] req_interval,
  input  logic                  abort,
  output logic                  set_cutoff_en,
  output logic [7:0]            cutoff_value,
  output logic [7:0]            current,
  output logic                  busy,
  output logic                  done
);

  // Handshake: a request transfers at a rising edge where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is IDLE.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [INTERVAL_W-1:0] INTERVAL_ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [7:0]            target_r;
  logic [7:0]            step_r;
  logic [INTERVAL_W-1:0] interval_r;
  logic [INTERVAL_W-1:0] timer;

  logic [7:0]            step_eff;
  logic [INTERVAL_W-1:0] interval_eff;
  logic [8:0]            up_sum;
  logic [8:0]            dn_diff;
  logic [7:0]            next_val;

  always_comb begin
    step_eff     = (req_step == 8'd0) ? 8'd1 : req_step;
    interval_eff = (req_interval == '0) ? INTERVAL_ONE : req_interval;
  end

  // 9-bit arithmetic so a large step clamps at the target instead of wrapping.
  always_comb begin
    up_sum   = {1'b0, current} + {1'b0, step_r};
    dn_diff  = {1'b0, current} - {1'b0, step_r};
    next_val = target_r;
    if (target_r > current) begin
      if (up_sum < {1'b0, target_r}) next_val = up_sum[7:0];
    end else begin
      if (!dn_diff[8] && (dn_diff[7:0] > target_r)) next_val = dn_diff[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      target_r      <= INIT_CUTOFF;
      step_r        <= 8'd1;
      interval_r    <= INTERVAL_ONE;
      timer         <= '0;
      current       <= INIT_CUTOFF;
      cutoff_value  <= INIT_CUTOFF;
      set_cutoff_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      set_cutoff_en <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target_r   <= req_target;
            step_r     <= step_eff;
            interval_r <= interval_eff;
            timer      <= interval_eff - INTERVAL_ONE;
            req_ready  <= 1'b0;
            if (req_target == current) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            timer     <= '0;
          end else if (timer != '0) begin
            timer <= timer - INTERVAL_ONE;
          end else begin
            set_cutoff_en <= 1'b1;
            cutoff_value  <= next_val;
            current       <= next_val;
            timer         <= interval_r - INTERVAL_ONE;
            if (next_val == target_r) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
